// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment scan driver.
// Scans NUM_DIGITS digits one slot at a time, decodes each nibble to
// active-low segments, blanks the first part of every slot to suppress
// ghosting, and snapshots its inputs once per frame so a scan never tears.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_hex,
  input  logic [NUM_DIGITS-1:0] i_digit_en,
  input  logic [NUM_DIGITS-1:0] i_dp,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic                  o_frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_e;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shadow_hex;
  logic [NUM_DIGITS-1:0] shadow_en;
  logic [NUM_DIGITS-1:0] shadow_dp;

  logic                  slot_end;
  logic                  last_digit;
  logic                  frame_edge;
  phase_e                phase;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  // Slot/frame position flags and the phase of the slot being emitted.
  // The first cycle of every slot is always blank so anodes never switch
  // directly from one digit to the next, even with BLANK_CYCLES = 0.
  always_comb begin
    slot_end   = (int'(cnt) == SCAN_DIV - 1);
    last_digit = (int'(idx) == NUM_DIGITS - 1);
    frame_edge = (cnt == '0) && (idx == '0);
    if ((cnt == '0) || (int'(cnt) < BLANK_CYCLES) || !shadow_en[idx]) begin
      phase = PH_BLANK;
    end else begin
      phase = PH_DRIVE;
    end
  end

  // Hex-to-segment decode, active-low, gfedcba.
  always_comb begin
    nibble = shadow_hex[{idx, 2'b00} +: 4];
    // NOTE: every combinational output gets a value on every path (here via
    // the default arm) so no latch is inferred.
    case (nibble)
      4'h0:    seg_dec = 7'h40;
      4'h1:    seg_dec = 7'h79;
      4'h2:    seg_dec = 7'h24;
      4'h3:    seg_dec = 7'h30;
      4'h4:    seg_dec = 7'h19;
      4'h5:    seg_dec = 7'h12;
      4'h6:    seg_dec = 7'h02;
      4'h7:    seg_dec = 7'h78;
      4'h8:    seg_dec = 7'h00;
      4'h9:    seg_dec = 7'h10;
      4'hA:    seg_dec = 7'h08;
      4'hB:    seg_dec = 7'h03;
      4'hC:    seg_dec = 7'h46;
      4'hD:    seg_dec = 7'h21;
      4'hE:    seg_dec = 7'h06;
      default: seg_dec = 7'h0E;
    endcase
  end

  // Next output values: all-off in BLANK, selected digit in DRIVE.
  always_comb begin
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (phase == PH_DRIVE) begin
      an_next  = ~(NUM_DIGITS'(1) << idx);
      seg_next = seg_dec;
      dp_next  = ~shadow_dp[idx];
    end
  end

  // Slot counter and digit index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= last_digit ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Once-per-frame input snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_hex <= '0;
      shadow_en  <= '0;
      shadow_dp  <= '0;
    end else if (frame_edge) begin
      shadow_hex <= i_hex;
      shadow_en  <= i_digit_en;
      shadow_dp  <= i_dp;
    end
  end

  // Registered outputs; asynchronous reset forces the display dark at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_an          <= '1;
      o_seg         <= 7'h7F;
      o_dp          <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_an          <= an_next;
      o_seg         <= seg_next;
      o_dp          <= dp_next;
      o_frame_start <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: two instances (BLANK_CYCLES=2 and 0)
// checked every cycle against a frame/slot arithmetic reference model,
// plus a decode-table sweep and hand-written corner sequences.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int FRAME = ND * SD;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t dec_tbl[16];

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hex;
  logic [3:0]  en;
  logic [3:0]  dp;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0, an1;
  logic        fs0, fs1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .DATA_WIDTH(32), .SCAN_DIV(SD), .BLANK_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .i_hex(hex), .i_digit_en(en), .i_dp(dp),
    .o_seg(seg0), .o_dp(dp0), .o_an(an0), .o_frame_start(fs0)
  );

  seg7_scan_driver #(.NUM_DIGITS(ND), .DATA_WIDTH(32), .SCAN_DIV(SD), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .i_hex(hex), .i_digit_en(en), .i_dp(dp),
    .o_seg(seg1), .o_dp(dp1), .o_an(an1), .o_frame_start(fs1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: n counts clock edges since reset release; the output in
  // the cycle after edge n is a pure function of n and the frame snapshot.
  bit          running = 0;
  int          n = 0;
  logic [31:0] s_hex;
  logic [3:0]  s_en, s_dp;
  int          cyc = 0;
  int          last_fs1 = -1;

  function automatic logic [12:0] model_out(input int blank_cycles);
    int t, k, pos;
    logic [3:0] an;
    logic fs;
    if (!running) return {4'hF, 7'h7F, 1'b1, 1'b0};
    t   = n % FRAME;
    k   = t / SD;
    pos = t % SD;
    fs  = (t == 0);
    if (pos == 0 || pos < blank_cycles || !s_en[k]) return {4'hF, 7'h7F, 1'b1, fs};
    an    = 4'hF;
    an[k] = 1'b0;
    return {an, dec_tbl[s_hex[4*k +: 4]].seg, ~s_dp[k], fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      running  = 0;
      last_fs1 = -1;
    end else begin
      if (!running) begin
        running = 1;
        n = 0;
      end else begin
        n++;
      end
      if (n % FRAME == 0) begin
        s_hex = hex;
        s_en  = en;
        s_dp  = dp;
      end
    end
    cyc++;
    @(negedge clk);
    check("u0_outputs", {19'd0, an0, seg0, dp0, fs0}, {19'd0, model_out(2)});
    check("u1_outputs", {19'd0, an1, seg1, dp1, fs1}, {19'd0, model_out(0)});
    if (fs1) begin
      if (last_fs1 >= 0) check("u1_fs_period", cyc - last_fs1, FRAME);
      last_fs1 = cyc;
    end
  endtask

  task automatic tick_until(input int t);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (running && (n % FRAME) == t) return;
    end
    check("tick_until_timeout", 0, 1);
  endtask

  initial begin
    int en_viol, dp_viol;
    dec_tbl = '{
      '{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
      '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
      '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
      '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}
    };

    // Reset and first frame.
    rst = 1'b1;
    hex = 32'h0000_4321;
    en  = 4'hF;
    dp  = 4'h0;
    #1;
    check("reset_an", {28'd0, an0}, 32'hF);
    check("reset_seg", {25'd0, seg0}, 32'h7F);
    check("reset_dp", {31'd0, dp0}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("first_fs", {31'd0, fs0}, 32'd1);
    tick_until(2);
    check("digit0_an", {28'd0, an0}, 32'hE);
    check("digit0_seg", {25'd0, seg0}, 32'h79);
    tick_until(9);
    hex = 32'h0000_FFFF;
    tick_until(SD + 4);
    check("tear_digit1", {25'd0, seg0}, 32'h24);
    tick_until(2 * SD + 2);
    check("tear_digit2", {25'd0, seg0}, 32'h30);
    tick_until(3 * SD + 7);
    check("tear_digit3", {25'd0, seg0}, 32'h19);
    tick_until(2);
    check("update_digit0", {25'd0, seg0}, 32'h0E);

    // Digit enable and decimal point.
    en = 4'b0101;
    dp = 4'b0100;
    tick_until(0);
    en_viol = 0;
    dp_viol = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (an0 == 4'b1101 || an0 == 4'b0111 || an1 == 4'b1101 || an1 == 4'b0111) en_viol++;
      if ((dp0 == 1'b0) != (an0 == 4'b1011)) dp_viol++;
    end
    check("disabled_anodes", en_viol, 0);
    check("dp_only_digit2", dp_viol, 0);

    // Full decode sweep through digit 0.
    en = 4'hF;
    dp = 4'h0;
    tick_until(4);
    for (int v = 0; v < 16; v++) begin
      hex = {28'h1234_567, dec_tbl[v].nib};
      tick_until(4);
      check("sweep_seg", {25'd0, seg0}, {25'd0, dec_tbl[v].seg});
    end

    // Reset mid-DRIVE, asynchronously between edges.
    tick_until(12);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_an0", {28'd0, an0}, 32'hF);
    check("async_rst_an1", {28'd0, an1}, 32'hF);
    check("async_rst_seg", {25'd0, seg0}, 32'h7F);
    hex = 32'h0000_9876;
    tick();
    rst = 1'b0;
    tick();
    check("restart_fs", {31'd0, fs0}, 32'd1);
    tick_until(SD + 3);
    check("restart_digit1", {25'd0, seg0}, 32'h78);

    // Randomized inputs changing at arbitrary cycles.
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) hex = $urandom;
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
